// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC bus fabric.
package soc_bus_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } bus_state_e;

   localparam logic [31:0] BUS_ERR_DATA  = 32'hDEAD_BEEF;
   localparam logic [15:0] RAM_PAGE      = 16'h0000;
   localparam logic [15:0] PER_BASE_PAGE = 16'h0040;

endpackage

// File: rtl/soc_bus_fabric_decode.sv
// soc_addr_decode: purely combinational page -> {hit, index} decoder.
// Page RAM_PAGE selects slave 0; pages BASE_PAGE .. BASE_PAGE+N_SLV-2 select slaves 1..N_SLV-1.
module soc_addr_decode
   import soc_bus_pkg::*;
#(
   parameter int unsigned N_SLV   = 8,
   parameter int unsigned PAGE_HI = 31,
   parameter int unsigned PAGE_LO = 16,
   parameter logic [PAGE_HI-PAGE_LO:0] BASE_PAGE = PER_BASE_PAGE,
   localparam int unsigned PW    = PAGE_HI - PAGE_LO + 1,
   localparam int unsigned IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
   input  logic [PW-1:0]    page,
   output logic             hit,
   output logic [IDX_W-1:0] idx
);

   logic [PW-1:0] offset;

   // Range compare against the peripheral window; idx is only meaningful when hit is set.
   always_comb begin
      offset = page - BASE_PAGE;
      hit    = 1'b0;
      idx    = '0;
      if (page == PW'(RAM_PAGE)) begin
         hit = 1'b1;
      end else if ((page >= BASE_PAGE) && (offset <= PW'(N_SLV - 2))) begin
         hit = 1'b1;
         idx = IDX_W'(offset + PW'(1));
      end
   end

endmodule

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: decoder, chip-select generator and read-data mux between the CPU memory port
// and N_SLV slaves, with per-slave busy stall, timeout watchdog and error capture.
// Optional: define BUS_ERR_TRAP_EN to trap unmapped accesses (no chip select, error data,
// error flag) instead of aliasing them onto slave 0.
module soc_bus_fabric
   import soc_bus_pkg::*;
#(
   parameter int unsigned N_SLV   = 8,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned PAGE_HI = 31,
   parameter int unsigned PAGE_LO = 16,
   parameter logic [PAGE_HI-PAGE_LO:0] BASE_PAGE = PER_BASE_PAGE,
   parameter int unsigned TIMEOUT = 255,
   localparam int unsigned IDX_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [ADDR_W-1:0]       m_addr,
   input  logic [DATA_W-1:0]       m_wdata,
   input  logic [3:0]              m_wmask,
   input  logic                    m_rstrb,
   output logic [DATA_W-1:0]       m_rdata,
   output logic                    m_rbusy,
   output logic                    m_wbusy,
   output logic [N_SLV-1:0]        s_cs,
   output logic                    s_rd,
   output logic                    s_wr,
   output logic [ADDR_W-1:0]       s_addr,
   output logic [DATA_W-1:0]       s_wdata,
   output logic [3:0]              s_wmask,
   input  logic [N_SLV*DATA_W-1:0] s_rdata,
   input  logic [N_SLV-1:0]        s_busy,
   input  logic                    err_clr,
   output logic                    err_irq,
   output logic [ADDR_W-1:0]       err_addr
);

   bus_state_e        state_q, state_d;
   logic [IDX_W-1:0]  sel_q, sel_d;
   logic              is_read_q, is_read_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              resp_q, resp_d;
   logic              miss_q, miss_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              err_irq_q, err_irq_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              dec_hit;
   logic [IDX_W-1:0]  dec_idx;
   logic [IDX_W-1:0]  dec_sel;
   logic              dec_miss;
   logic [N_SLV-1:0]  dec_cs;
   logic [N_SLV-1:0]  sel_onehot;
   logic              busy_sel;
   logic [DATA_W-1:0] sel_data;
   logic              req;
   logic              stall;
   logic              err_set;

   soc_addr_decode #(
      .N_SLV     (N_SLV),
      .PAGE_HI   (PAGE_HI),
      .PAGE_LO   (PAGE_LO),
      .BASE_PAGE (BASE_PAGE)
   ) u_decode (
      .page (m_addr[PAGE_HI:PAGE_LO]),
      .hit  (dec_hit),
      .idx  (dec_idx)
   );

   // Map the decoder result onto a chip select, trapping or aliasing unmapped pages.
   always_comb begin
      dec_cs = '0;
`ifdef BUS_ERR_TRAP_EN
      dec_sel  = dec_idx;
      dec_miss = ~dec_hit;
      if (dec_hit) dec_cs[dec_idx] = 1'b1;
`else
      dec_sel  = dec_hit ? dec_idx : '0;
      dec_miss = 1'b0;
      dec_cs[dec_sel] = 1'b1;
`endif
   end

   // Latched-slave views: one-hot select, its busy line and its read data.
   always_comb begin
      sel_onehot        = '0;
      sel_onehot[sel_q] = 1'b1;
      busy_sel          = s_busy[sel_q] & ~miss_q;
      sel_data          = s_rdata[32'(sel_q) * DATA_W +: DATA_W];
      req               = m_rstrb | (|m_wmask);
   end

   // Transaction FSM: next state, strobes, stalls and response data.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      is_read_d = is_read_q;
      addr_d    = addr_q;
      resp_d    = 1'b0;
      miss_d    = miss_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      err_set   = 1'b0;
      stall     = 1'b0;
      s_cs      = '0;
      s_rd      = 1'b0;
      s_wr      = 1'b0;
      m_rbusy   = 1'b0;
      m_wbusy   = 1'b0;
      if (resetn) begin
         unique case (state_q)
            IDLE: begin
               if (resp_q) begin
                  if (miss_q) begin
                     err_set = 1'b1;
                     if (is_read_q) rdata_d = DATA_W'(BUS_ERR_DATA);
                  end else if (busy_sel) begin
                     // Slave not ready: stall the CPU from this very cycle.
                     stall   = 1'b1;
                     state_d = WAIT;
                     cnt_d   = '0;
                     s_cs    = sel_onehot;
                     m_rbusy = is_read_q;
                     m_wbusy = ~is_read_q;
                  end else if (is_read_q) begin
                     rdata_d = sel_data;
                  end
               end
               if (req && !stall) begin
                  s_cs      = dec_cs;
                  s_rd      = m_rstrb;
                  s_wr      = |m_wmask;
                  sel_d     = dec_sel;
                  is_read_d = m_rstrb;
                  addr_d    = m_addr;
                  miss_d    = dec_miss;
                  resp_d    = 1'b1;
               end
            end
            WAIT: begin
               s_cs = sel_onehot;
               if (!busy_sel) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  if (is_read_q) rdata_d = sel_data;
               end else if (cnt_q == 8'(TIMEOUT)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  err_set = 1'b1;
                  rdata_d = DATA_W'(BUS_ERR_DATA);
               end else begin
                  m_rbusy = is_read_q;
                  m_wbusy = ~is_read_q;
                  if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Sticky error flag; a new error overrides a simultaneous clear and recaptures the address.
   always_comb begin
      err_irq_d  = err_irq_q;
      err_addr_d = err_addr_q;
      if (err_clr) err_irq_d = 1'b0;
      if (err_set) begin
         err_irq_d = 1'b1;
         if (!err_irq_q || err_clr) err_addr_d = addr_q;
      end
   end

   // Output drive; everything is forced low while reset is asserted.
   always_comb begin
      m_rdata  = resetn ? rdata_d : '0;
      s_addr   = resetn ? m_addr : '0;
      s_wdata  = resetn ? m_wdata : '0;
      s_wmask  = m_wmask & {4{s_cs[0] & s_wr}};
      err_irq  = resetn & err_irq_q;
      err_addr = resetn ? err_addr_q : '0;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         is_read_q  <= 1'b0;
         addr_q     <= '0;
         resp_q     <= 1'b0;
         miss_q     <= 1'b0;
         cnt_q      <= '0;
         err_irq_q  <= 1'b0;
         err_addr_q <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         is_read_q  <= is_read_d;
         addr_q     <= addr_d;
         resp_q     <= resp_d;
         miss_q     <= miss_d;
         cnt_q      <= cnt_d;
         err_irq_q  <= err_irq_d;
         err_addr_q <= err_addr_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: doc/soc_bus_fabric.md
Name: soc_bus_fabric

Overview:
Parametrised address decoder, chip-select generator and read-data multiplexer between the FemtoRV32 memory port and N_SLV slaves (RAM plus memory-mapped peripherals).
- Adds per-slave busy handshake, which drives the CPU's mem_rbusy/mem_wbusy.
- Adds a bus-timeout watchdog and an error-capture register.
- Sits at SOC top level, between the CPU and RAM/uart/mult/div/sqrt/bin2bcd.

Parameters:
N_SLV, 8, number of slaves; slave 0 is RAM.
ADDR_W, 32, address width.
DATA_W, 32, data width.
PAGE_HI, 31, MSB of page field in address.
PAGE_LO, 16, LSB of page field in address.
BASE_PAGE, 16'h0040, page of slave 1; slave i (i>=1) lives at page BASE_PAGE+i-1.
TIMEOUT, 255, max WAIT cycles before abort (8-bit counter, 1..255).

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
m_addr  in  ADDR_W  CPU address
m_wdata  in  DATA_W  CPU write data
m_wmask  in  4  CPU byte write mask
m_rstrb  in  1  CPU read strobe
m_rdata  out  DATA_W  read data to CPU
m_rbusy  out  1  read stall to CPU
m_wbusy  out  1  write stall to CPU
s_cs  out  N_SLV  one-hot chip select
s_rd  out  1  read strobe to slaves (gated by s_cs at slave)
s_wr  out  1  write strobe to slaves
s_addr  out  ADDR_W  address passthrough
s_wdata  out  DATA_W  write data passthrough
s_wmask  out  4  m_wmask AND-gated by s_cs[0]; RAM only
s_rdata  in  N_SLV*DATA_W  flattened slave read data; slave i at [i*DATA_W +: DATA_W]
s_busy  in  N_SLV  per-slave busy
err_clr  in  1  clear error flag
err_irq  out  1  sticky bus-error flag
err_addr  out  ADDR_W  address of first uncleared error

Behaviour:
- Reset: all outputs 0, state IDLE, sel_q=0, timeout counter 0, err_irq=0, err_addr=0.
- Decode (combinational from m_addr page):
  - page==0 -> slave 0.
  - BASE_PAGE <= page <= BASE_PAGE+N_SLV-2 -> slave page-BASE_PAGE+1.
  - Otherwise -> unmapped (see Optional Feature).
- s_cs is exactly one-hot or all-zero.
- Request = m_rstrb | (|m_wmask). s_rd=m_rstrb and s_wr=|m_wmask only in IDLE; both are 0 in WAIT.
- FSM states: IDLE, WAIT.
  - IDLE, request: s_cs driven from decode; latch sel_q, is_read_q, addr_q. Next cycle is the response cycle.
  - Response cycle: if s_busy[sel_q]=0 -> m_rdata = s_rdata[sel_q] (read), stay IDLE, 1-cycle latency as today. If s_busy[sel_q]=1 -> go to WAIT; m_rbusy (read) or m_wbusy (write) asserts combinationally in this same cycle.
  - WAIT: s_cs held at onehot(sel_q); busy output held; counter increments per cycle.
  - WAIT exit on s_busy[sel_q]=0: drop busy; m_rdata = s_rdata[sel_q] that cycle; back to IDLE.
  - WAIT exit on counter==TIMEOUT: drop busy; m_rdata = 32'hDEAD_BEEF; set err_irq; capture addr_q into err_addr (only if err_irq was 0); back to IDLE.
- m_rdata is only defined on response cycles; otherwise it holds its last value.
- A new request while in WAIT is ignored; the CPU must stall.
- err_clr and a new error in the same cycle: error wins and err_addr updates.
- resetn low in WAIT: IDLE next edge, busy outputs low the same cycle resetn is sampled.
- TIMEOUT counter saturates; it never wraps.

Optional Feature:
Macro BUS_ERR_TRAP_EN.
- Defined: an unmapped access asserts no s_cs. Reads return 32'hDEAD_BEEF; writes are dropped. Either sets err_irq/err_addr with zero wait states.
- Undefined: unmapped pages alias to slave 0 (legacy behaviour); err_irq is raised only by timeout.

Decomposition:
- Package soc_bus_pkg: FSM state encoding (IDLE, WAIT); BUS_ERR_DATA = 32'hDEAD_BEEF; default page constants RAM_PAGE=16'h0000 and PER_BASE_PAGE=16'h0040.
- One sub-module soc_addr_decode: purely combinational page -> {hit, index}, parametrised on N_SLV, PAGE_HI, PAGE_LO, BASE_PAGE.

Test Plan:
1. Read at 0x0000_0010, s_busy=0, s_rdata[0]=0x12345678 -> s_cs=0x01; m_rdata=0x12345678 next cycle; m_rbusy never high.
2. Write 0x0042_0004 wmask=4'hF, s_busy[3] high for 5 cycles -> s_cs=0x08 held; m_wbusy high 5 cycles; s_wr single pulse; s_wmask=0.
3. Read 0x0041_0000, s_busy[2] stuck high, TIMEOUT=255 -> m_rbusy low after 255 WAIT cycles; m_rdata=0xDEADBEEF; err_irq=1; err_addr=0x0041_0000.
4. BUS_ERR_TRAP_EN, read 0x0099_0000 -> s_cs=0; m_rdata=0xDEADBEEF; err_irq=1. Without the macro -> s_cs=0x01 and RAM data returned.
5. err_clr in the same cycle as a second error at 0x0043_0000, with err_irq already 1 -> err_irq stays 1; err_addr=0x0043_0000.
6. resetn low on the 3rd WAIT cycle -> m_rbusy=0, s_cs=0, counter 0; the next read completes normally.
